// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared constants for the traffic sensor front-end and its consumers.
// Direction indices are also used by the light controller and the benches.
package traffic_sensor_conditioner_pkg;

  localparam int DIR_NS   = 0;
  localparam int DIR_SN   = 1;
  localparam int DIR_EW   = 2;
  localparam int DIR_WE   = 3;
  localparam int NUM_DIRS = 4;

  localparam int CNT_W_DEF    = 6;
  localparam int MAX_CNT_DEF  = 63;
  localparam int CONG_ON_DEF  = 5;
  localparam int CONG_OFF_DEF = 3;
  localparam int DEB_CYC_DEF  = 3;

endpackage

// File: rtl/traffic_sensor_conditioner_lane_queue_counter.sv
// One approach lane: synchronises and debounces the arrival and departure
// loops, then keeps a saturating queue count with presence, congestion
// (hysteresis) and sticky underflow flags.
module lane_queue_counter
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_CNT  = MAX_CNT_DEF,
  parameter int CONG_ON  = CONG_ON_DEF,
  parameter int CONG_OFF = CONG_OFF_DEF,
  parameter int DEB_CYC  = DEB_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             arr_raw,
  input  logic             dep_raw,
  output logic             s1,
  output logic             s5,
  output logic [CNT_W-1:0] q,
  output logic             err
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  // Bit 0 carries the arrival detector, bit 1 the departure detector.
  logic [1:0]         raw;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         acc_q, acc_d;
  logic [1:0]         evt_q, evt_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic             s1_q, s1_d;
  logic             s5_q, s5_d;
  logic             err_q, err_d;

  assign raw = {dep_raw, arr_raw};

  // Debounce: a level must disagree for DEB_CYC consecutive cycles before it
  // is accepted; only an accepted rising edge produces an event pulse.
  always_comb begin
    acc_d     = acc_q;
    evt_d     = '0;
    deb_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != acc_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          acc_d[i] = ~acc_q[i];
          evt_d[i] = ~acc_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Detector pipeline registers; clr deliberately leaves these running so a
  // detector held across a clear does not generate a fresh event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      evt_q     <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      acc_q     <= acc_d;
      evt_q     <= evt_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Queue update from the event pulses; flags are derived from the next
  // count so they change on the same edge as the count itself.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    s5_d    = s5_q;
    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
      s5_d    = 1'b0;
    end else begin
      case (evt_q)
        2'b01: begin
          if (int'(count_q) < MAX_CNT) count_d = count_q + 1'b1;
        end
        2'b10: begin
          if (count_q == '0) err_d = 1'b1;
          else count_d = count_q - 1'b1;
        end
        default: count_d = count_q;
      endcase
      if (int'(count_d) >= CONG_ON) s5_d = 1'b1;
      else if (int'(count_d) < CONG_OFF) s5_d = 1'b0;
    end
    s1_d = (count_d != '0);
  end

  // Queue state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      s1_q    <= 1'b0;
      s5_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      s1_q    <= s1_d;
      s5_q    <= s5_d;
      err_q   <= err_d;
    end
  end

  assign q   = count_q;
  assign s1  = s1_q;
  assign s5  = s5_q;
  assign err = err_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Four independent lane counters producing the S1/S5 flags consumed by the
// adaptive traffic light controller.
module traffic_sensor_conditioner
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_CNT  = MAX_CNT_DEF,
  parameter int CONG_ON  = CONG_ON_DEF,
  parameter int CONG_OFF = CONG_OFF_DEF,
  parameter int DEB_CYC  = DEB_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             arr_NS,
  input  logic             arr_SN,
  input  logic             arr_EW,
  input  logic             arr_WE,
  input  logic             dep_NS,
  input  logic             dep_SN,
  input  logic             dep_EW,
  input  logic             dep_WE,
  output logic             S1_NS,
  output logic             S1_SN,
  output logic             S1_EW,
  output logic             S1_WE,
  output logic             S5_NS,
  output logic             S5_SN,
  output logic             S5_EW,
  output logic             S5_WE,
  output logic [CNT_W-1:0] q_NS,
  output logic [CNT_W-1:0] q_SN,
  output logic [CNT_W-1:0] q_EW,
  output logic [CNT_W-1:0] q_WE,
  output logic             err_NS,
  output logic             err_SN,
  output logic             err_EW,
  output logic             err_WE
);

  logic [NUM_DIRS-1:0] arr, dep, s1, s5, err;
  logic [CNT_W-1:0]    q [NUM_DIRS];

  assign arr[DIR_NS] = arr_NS;
  assign arr[DIR_SN] = arr_SN;
  assign arr[DIR_EW] = arr_EW;
  assign arr[DIR_WE] = arr_WE;
  assign dep[DIR_NS] = dep_NS;
  assign dep[DIR_SN] = dep_SN;
  assign dep[DIR_EW] = dep_EW;
  assign dep[DIR_WE] = dep_WE;

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_lane
    lane_queue_counter #(
      .CNT_W   (CNT_W),
      .MAX_CNT (MAX_CNT),
      .CONG_ON (CONG_ON),
      .CONG_OFF(CONG_OFF),
      .DEB_CYC (DEB_CYC)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .arr_raw(arr[d]),
      .dep_raw(dep[d]),
      .s1     (s1[d]),
      .s5     (s5[d]),
      .q      (q[d]),
      .err    (err[d])
    );
  end

  assign S1_NS  = s1[DIR_NS];
  assign S1_SN  = s1[DIR_SN];
  assign S1_EW  = s1[DIR_EW];
  assign S1_WE  = s1[DIR_WE];
  assign S5_NS  = s5[DIR_NS];
  assign S5_SN  = s5[DIR_SN];
  assign S5_EW  = s5[DIR_EW];
  assign S5_WE  = s5[DIR_WE];
  assign q_NS   = q[DIR_NS];
  assign q_SN   = q[DIR_SN];
  assign q_EW   = q[DIR_EW];
  assign q_WE   = q[DIR_WE];
  assign err_NS = err[DIR_NS];
  assign err_SN = err[DIR_SN];
  assign err_EW = err[DIR_EW];
  assign err_WE = err[DIR_WE];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: a vector table for the
// counting behaviour plus hand-written latency, glitch, clear, saturation
// and reset sequences. Mask bit order is NS, SN, EW, WE (bit 0 .. bit 3).
module tb_traffic_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic       arr_NS, arr_SN, arr_EW, arr_WE;
  logic       dep_NS, dep_SN, dep_EW, dep_WE;
  logic       S1_NS, S1_SN, S1_EW, S1_WE;
  logic       S5_NS, S5_SN, S5_EW, S5_WE;
  logic [5:0] q_NS, q_SN, q_EW, q_WE;
  logic       err_NS, err_SN, err_EW, err_WE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] arr;
    logic [3:0] dep;
    int         q_ns, q_sn, q_ew, q_we;
    logic [3:0] s5;
    logic [3:0] err;
  } vec_t;

  vec_t vecs[17];

  traffic_sensor_conditioner dut (
    .clk(clk), .rst(rst), .clr(clr),
    .arr_NS(arr_NS), .arr_SN(arr_SN), .arr_EW(arr_EW), .arr_WE(arr_WE),
    .dep_NS(dep_NS), .dep_SN(dep_SN), .dep_EW(dep_EW), .dep_WE(dep_WE),
    .S1_NS(S1_NS), .S1_SN(S1_SN), .S1_EW(S1_EW), .S1_WE(S1_WE),
    .S5_NS(S5_NS), .S5_SN(S5_SN), .S5_EW(S5_EW), .S5_WE(S5_WE),
    .q_NS(q_NS), .q_SN(q_SN), .q_EW(q_EW), .q_WE(q_WE),
    .err_NS(err_NS), .err_SN(err_SN), .err_EW(err_EW), .err_WE(err_WE)
  );

  // 4 ns clock period.
  always #2 clk = ~clk;

  // Single comparison; every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare all four directions against bench-supplied queue counts and masks.
  task automatic checkState(input string name, input int qns, input int qsn, input int qew,
                            input int qwe, input logic [3:0] s5m, input logic [3:0] errm);
    logic [23:0] exp_q;
    logic [3:0]  exp_s1;
    exp_q  = {6'(qwe), 6'(qew), 6'(qsn), 6'(qns)};
    exp_s1 = {qwe != 0, qew != 0, qsn != 0, qns != 0};
    checkOutput({name, ".q"},   32'({q_WE, q_EW, q_SN, q_NS}),         32'(exp_q));
    checkOutput({name, ".s1"},  32'({S1_WE, S1_EW, S1_SN, S1_NS}),     32'(exp_s1));
    checkOutput({name, ".s5"},  32'({S5_WE, S5_EW, S5_SN, S5_NS}),     32'(s5m));
    checkOutput({name, ".err"}, 32'({err_WE, err_EW, err_SN, err_NS}), 32'(errm));
  endtask

  // Clean pulse: masks held high 6 cycles, then low 6 cycles to settle.
  task automatic applyStimulus(input logic [3:0] am, input logic [3:0] dm);
    @(negedge clk);
    {arr_WE, arr_EW, arr_SN, arr_NS} = am;
    {dep_WE, dep_EW, dep_SN, dep_NS} = dm;
    repeat (6) @(negedge clk);
    {arr_WE, arr_EW, arr_SN, arr_NS} = '0;
    {dep_WE, dep_EW, dep_SN, dep_NS} = '0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0010, 4'b0000, 1, 2, 0, 0, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0110, 4'b0000, 1, 3, 1, 0, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0010, 4'b0000, 1, 4, 1, 0, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0010, 4'b0000, 1, 5, 1, 0, 4'b0010, 4'b0000};
    vecs[5]  = '{4'b0010, 4'b0000, 1, 6, 1, 0, 4'b0010, 4'b0000};
    vecs[6]  = '{4'b0000, 4'b0010, 1, 5, 1, 0, 4'b0010, 4'b0000};
    vecs[7]  = '{4'b0000, 4'b0010, 1, 4, 1, 0, 4'b0010, 4'b0000};
    vecs[8]  = '{4'b0000, 4'b0010, 1, 3, 1, 0, 4'b0010, 4'b0000};
    vecs[9]  = '{4'b0000, 4'b0010, 1, 2, 1, 0, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0000, 4'b0010, 1, 1, 1, 0, 4'b0000, 4'b0000};
    vecs[11] = '{4'b0000, 4'b0010, 1, 0, 1, 0, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0000, 4'b1000, 1, 0, 1, 0, 4'b0000, 4'b1000};
    vecs[13] = '{4'b1000, 4'b0000, 1, 0, 1, 1, 4'b0000, 4'b1000};
    vecs[14] = '{4'b0001, 4'b0000, 2, 0, 1, 1, 4'b0000, 4'b1000};
    vecs[15] = '{4'b0001, 4'b0001, 2, 0, 1, 1, 4'b0000, 4'b1000};
    vecs[16] = '{4'b0010, 4'b0010, 2, 0, 1, 1, 4'b0000, 4'b1000};

    rst = 1'b1;
    clr = 1'b0;
    {arr_WE, arr_EW, arr_SN, arr_NS} = '0;
    {dep_WE, dep_EW, dep_SN, dep_NS} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkState("reset", 0, 0, 0, 0, 4'b0000, 4'b0000);

    // Exact latency: count changes on the DEB_CYC+2-th edge after first sample.
    $display("[TB] latency sequence");
    @(negedge clk);
    arr_NS = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e >= 3 && e <= 5) checkOutput($sformatf("latency.q_NS.e%0d", e), 32'(q_NS), (e >= 5) ? 32'd1 : 32'd0);
      if (e == 4) arr_NS = 1'b0;
    end
    repeat (8) @(negedge clk);
    checkState("latency", 1, 0, 0, 0, 4'b0000, 4'b0000);

    // Two-cycle glitch must never be accepted.
    $display("[TB] glitch sequence");
    @(negedge clk);
    arr_EW = 1'b1;
    repeat (2) @(negedge clk);
    arr_EW = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("glitch.EW", 32'({S1_EW, q_EW}), 32'd0);
    end

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].arr, vecs[i].dep);
      checkState($sformatf("vec%0d", i), vecs[i].q_ns, vecs[i].q_sn, vecs[i].q_ew,
                 vecs[i].q_we, vecs[i].s5, vecs[i].err);
    end

    // Clear with arr_WE held high across it: pending work is discarded and
    // the held detector does not produce a new event.
    $display("[TB] clear sequence");
    @(negedge clk);
    arr_WE = 1'b1;
    repeat (10) @(negedge clk);
    checkState("pre_clr", 2, 0, 1, 2, 4'b0000, 4'b1000);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    checkState("post_clr", 0, 0, 0, 0, 4'b0000, 4'b0000);
    arr_WE = 1'b0;
    repeat (8) @(negedge clk);

    // Saturation at 63 without wrap.
    $display("[TB] saturation sequence");
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(4'b0001, 4'b0000);
      if (i >= 62) checkOutput($sformatf("sat.q_NS.%0d", i), 32'(q_NS), (i > 63) ? 32'd63 : 32'(i));
    end
    checkState("sat", 63, 0, 0, 0, 4'b0001, 4'b0000);

    // Reset mid-count with arr_EW held through the release.
    $display("[TB] reset sequence");
    repeat (4) applyStimulus(4'b0100, 4'b0000);
    checkState("pre_rst", 63, 0, 4, 0, 4'b0001, 4'b0000);
    @(negedge clk);
    arr_EW = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkState("rst_release", 0, 0, 0, 0, 4'b0000, 4'b0000);
    repeat (8) @(negedge clk);
    checkState("rst_event", 0, 0, 1, 0, 4'b0000, 4'b0000);
    repeat (10) @(negedge clk);
    arr_EW = 1'b0;
    repeat (8) @(negedge clk);
    checkState("rst_single", 0, 0, 1, 0, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
